c2p_frame_sequencer: RTL and testbench

Sequences the load of one cartesian image frame into the car2pol mapping core. Replaces per-pixel software register writes (map, inp_image, w_addr, inp_valid). Accepts a pixel stream from the frame source and selects the map at frame start. Generates incrementing write addresses and drives the core's write port with a valid/ready handshake. Sits between the frame DMA/FIFO and the car2pol core inside the display block design; the AXI-lite register block triggers it.

---
 rtl/c2p_frame_sequencer_if.sv | 33 +++
 rtl/c2p_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_c2p_frame_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c2p_frame_sequencer_if.sv
// Purpose : pixel-stream input and core write-port bundle for the car2pol frame sequencer.
// Latency : none (wires only).
// Backpressure: pix_valid/pix_ready on the source side, core_valid/core_ready on the core side.
//
// Ports (signals):
//   pix_data/pix_valid/pix_ready               pixel stream from frame DMA/FIFO
//   core_map/core_image/core_w_addr/core_valid  write port into the car2pol core
//   core_ready                                  core accepts the presented write
// Modports: master = sequencer side, slave = source/core side.
interface c2p_frame_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int MAP_W  = 3
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [MAP_W-1:0]  core_map;
    logic [DATA_W-1:0] core_image;
    logic [ADDR_W-1:0] core_w_addr;
    logic              core_valid;
    logic              core_ready;

    modport master (
        input  pix_data, pix_valid, core_ready,
        output pix_ready, core_map, core_image, core_w_addr, core_valid
    );

    modport slave (
        output pix_data, pix_valid, core_ready,
        input  pix_ready, core_map, core_image, core_w_addr, core_valid
    );
endinterface

// File: rtl/c2p_frame_sequencer.sv
// Purpose : loads one cartesian frame into the car2pol core: captures map/base on start,
//           forwards NUM_PIX pixels with incrementing (wrapping) write addresses.
// Latency : pixel accepted at edge k appears on core_* after edge k; 1 pixel/cycle sustained.
// Backpressure: single output register; pix_ready drops while a write is held (core_ready=0).
//
// Ports: aclk, aresetn (async active-low); start/abort/map_sel/base_addr control;
//        bus (master modport) pixel stream in + core write port out;
//        busy (not IDLE), done (1-cycle frame complete), frame_cnt (wrapping), err (sticky timeout).
// Optional: define C2P_SEQ_TIMEOUT_EN to abandon a frame after TIMEOUT_CYC consecutive
//           LOAD cycles without a pixel and raise err; otherwise err is 0 and the wait is unbounded.
module c2p_frame_sequencer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int NUM_PIX     = 1024,
    parameter int MAP_W       = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MAP_W-1:0]      map_sel,
    input  logic [ADDR_W-1:0]     base_addr,
    c2p_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic                  err
);
    localparam int CNT_W = $clog2(NUM_PIX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIX);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [MAP_W-1:0]  map_q, map_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] image_q, image_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic pix_rdy;
    logic pix_acc;
    logic start_acc;

    // Accept a pixel only while pixels remain and the output register is free
    // or is being emptied this cycle.
    assign pix_rdy   = (state_q == S_LOAD) && (count_q < LAST) && (!valid_q || bus.core_ready);
    assign pix_acc   = bus.pix_valid && pix_rdy;
    // abort takes priority over start even in IDLE
    assign start_acc = (state_q == S_IDLE) && start && !abort;

`ifdef C2P_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
    logic               waiting;
    logic               timeout;

    assign waiting = (state_q == S_LOAD) && (count_q < LAST);

    always_comb begin
        stall_d = '0;
        err_d   = err_q;
        timeout = 1'b0;
        if (waiting && !pix_acc) begin
            if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
        if (start_acc) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    // timeout disabled: constant 0
    assign err = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        map_d   = map_q;
        base_d  = base_q;
        valid_d = valid_q;
        image_d = image_q;
        waddr_d = waddr_q;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    map_d   = map_sel;
                    base_d  = base_addr;
                    count_d = '0;
                    state_d = S_SETUP;
                end
            end
            // one cycle so core_map is settled before the first write
            S_SETUP: state_d = S_LOAD;
            S_LOAD: begin
                if (pix_acc) begin
                    image_d = bus.pix_data;
                    waddr_d = base_q + ADDR_W'(count_q);
                    valid_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else if (valid_q && bus.core_ready) begin
                    valid_d = 1'b0;
                end
                if (count_d == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!valid_q || bus.core_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                fcnt_d  = fcnt_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            fcnt_d  = fcnt_q;
        end
`ifdef C2P_SEQ_TIMEOUT_EN
        if (timeout) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            map_q   <= '0;
            base_q  <= '0;
            valid_q <= 1'b0;
            image_q <= '0;
            waddr_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            map_q   <= map_d;
            base_q  <= base_d;
            valid_q <= valid_d;
            image_q <= image_d;
            waddr_q <= waddr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.pix_ready   = pix_rdy;
    assign bus.core_map    = map_q;
    assign bus.core_image  = image_q;
    assign bus.core_w_addr = waddr_q;
    assign bus.core_valid  = valid_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign frame_cnt       = fcnt_q;
endmodule

// File: tb/tb_c2p_frame_sequencer.sv
// Purpose : self-checking bench for c2p_frame_sequencer (directed frames + randomized frames).
// Latency : n/a.
// Backpressure: randomized pix_valid and core_ready, plus a targeted core_ready hold.
module tb_c2p_frame_sequencer;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int NUM_PIX     = 4;
    localparam int MAP_W       = 3;
    localparam int TIMEOUT_CYC = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [MAP_W-1:0]  map_sel = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, err;
    logic [15:0]       frame_cnt;

    c2p_frame_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAP_W(MAP_W)) bus ();

    c2p_frame_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PIX(NUM_PIX),
        .MAP_W(MAP_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .map_sel(map_sel), .base_addr(base_addr), .bus(bus),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    wr_t               exp_q[$];
    wr_t               wlog[$];
    wr_t               slog[$];
    int                wcyc[$];
    int                cyc = 0;
    int                exp_frames = 0;
    int                idx = 0;
    int                done_cnt = 0;
    int                stall_prdy = 0;
    logic [MAP_W-1:0]  exp_map = '0;
    logic [ADDR_W-1:0] exp_base = '0;
    bit                p_stall, p_abort, p_busy, p_done;
    wr_t               p_wr, cur, nw;

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            chk("reset_outputs", {bus.pix_ready, bus.core_map, bus.core_image, bus.core_w_addr,
                                  bus.core_valid, busy, done, frame_cnt, err}, 64'd0);
            exp_q.delete();
            exp_frames = 0;
            exp_map = '0;
            exp_base = '0;
            idx = 0;
            p_stall = 0; p_abort = 0; p_busy = 0; p_done = 0;
        end else begin
            cur.a = bus.core_w_addr;
            cur.d = bus.core_image;
            chk("frame_cnt", frame_cnt, exp_frames[15:0]);
            chk("core_map", bus.core_map, exp_map);
`ifndef C2P_SEQ_TIMEOUT_EN
            chk("err_tied", err, 0);
`endif
            if (p_stall && !p_abort && busy)
                chk("hold_stable", {bus.core_valid, cur}, {1'b1, p_wr});
            chk("pix_ready_gate", bus.pix_ready && ((bus.core_valid && !bus.core_ready) || !busy), 0);
            if (bus.core_valid && bus.core_ready) begin
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("write", cur, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                wlog.push_back(cur);
                wcyc.push_back(cyc);
            end
            if (bus.core_valid && !bus.core_ready) begin
                slog.push_back(cur);
                if (bus.pix_ready) stall_prdy++;
            end
            if (bus.pix_valid && bus.pix_ready && !abort) begin
                chk("pixel_overrun", idx >= NUM_PIX, 0);
                nw.a = exp_base + ADDR_W'(idx);
                nw.d = bus.pix_data;
                exp_q.push_back(nw);
                idx++;
            end
            if (done) begin
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_pixels", idx, NUM_PIX);
                chk("done_single", p_done, 0);
                if (!abort) exp_frames++;
                done_cnt++;
            end
            if (p_busy && !busy && !p_done && !p_abort) begin
`ifdef C2P_SEQ_TIMEOUT_EN
                chk("timeout_err", err, 1);
`else
                chk("unexpected_idle", busy, 1);
`endif
                exp_q.delete();
            end
            if (abort && busy) exp_q.delete();
            if (start && !abort && !busy) begin
                exp_map = map_sel;
                exp_base = base_addr;
                idx = 0;
                exp_q.delete();
            end
            p_stall = bus.core_valid && !bus.core_ready;
            p_wr    = cur;
            p_abort = abort;
            p_busy  = busy;
            p_done  = done;
        end
    end

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] src_q[$];
    int                vprob = 100;
    int                rprob = 100;
    int                hold_left = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    int                acc_cnt = 0;
    bit                s_hs, s_done, s_busy;

    task automatic step();
        @(negedge aclk);
        s_hs   = bus.pix_valid && bus.pix_ready && !abort;
        s_done = done;
        s_busy = busy;
        @(posedge aclk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (s_hs && src_q.size() > 0) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        if (!(bus.pix_valid && !s_hs))
            bus.pix_valid = ($urandom_range(99) < vprob);
        if (src_q.size() == 0) bus.pix_valid = 1'b0;
        bus.pix_data = (src_q.size() > 0) ? src_q[0] : '0;
        if (hold_left > 0 && bus.core_valid && bus.core_w_addr == hold_addr) begin
            bus.core_ready = 1'b0;
            hold_left--;
        end else begin
            bus.core_ready = ($urandom_range(99) < rprob);
        end
    endtask

    task automatic run_frame(input logic [MAP_W-1:0] m, input logic [ADDR_W-1:0] b,
                             input int st_at, input int ab_at, output bit got);
        bit fin, st_done, ab_done;
        fin = 0; st_done = 0; ab_done = 0; got = 0;
        wlog.delete(); wcyc.delete(); slog.delete(); stall_prdy = 0;
        map_sel = m; base_addr = b; start = 1'b1; acc_cnt = 0;
        step();
        chk("setup_busy", busy, 1);
        chk("setup_map", bus.core_map, m);
        for (int c = 0; c < 300 && !fin; c++) begin
            if (st_at >= 0 && !st_done && acc_cnt == st_at) begin
                start = 1'b1; map_sel = ~m; base_addr = b + 4'd5; st_done = 1;
            end
            if (ab_at >= 0 && !ab_done && acc_cnt == ab_at) begin
                abort = 1'b1; ab_done = 1;
            end
            step();
            if (s_done) begin got = 1; fin = 1; end
            else if (!s_busy) fin = 1;
        end
        chk("frame_budget", fin, 1);
        src_q.delete();
        bus.pix_valid = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NUM_PIX; i++) src_q.push_back($urandom);
    endtask

    bit got;
    int d0;
    logic [DATA_W-1:0] sent[NUM_PIX];
    int wrap_addr[NUM_PIX] = '{14, 15, 0, 1};

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data = '0;
        bus.core_ready = 1'b1;
        aresetn = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_pix_ready", bus.pix_ready, 0);

        // basic frame
        d0 = done_cnt;
        for (int i = 0; i < NUM_PIX; i++) src_q.push_back(5 + i);
        run_frame(7, 4, -1, -1, got);
        chk("t1_done", got, 1);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t1_addr", wlog[i].a, 4 + i);
            chk("t1_data", wlog[i].d, 5 + i);
            chk("t1_b2b", wcyc[i] - wcyc[0], i);
        end
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_busy_after", busy, 0);

        // backpressure on the write carrying pixel 6
        hold_addr = 4'd5; hold_left = 3;
        for (int i = 0; i < NUM_PIX; i++) src_q.push_back(5 + i);
        run_frame(7, 4, -1, -1, got);
        chk("t2_done", got, 1);
        chk("t2_stall_cycles", slog.size(), 3);
        for (int i = 0; i < slog.size(); i++) begin
            chk("t2_hold_addr", slog[i].a, 5);
            chk("t2_hold_data", slog[i].d, 6);
        end
        chk("t2_pix_ready_stall", stall_prdy, 0);
        chk("t2_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t2_addr", wlog[i].a, 4 + i);
            chk("t2_data", wlog[i].d, 5 + i);
        end
        chk("t2_frame_cnt", frame_cnt, 2);

        // address wrap
        for (int i = 0; i < NUM_PIX; i++) begin sent[i] = $urandom; src_q.push_back(sent[i]); end
        run_frame(1, 14, -1, -1, got);
        chk("t3_done", got, 1);
        chk("t3_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t3_addr", wlog[i].a, wrap_addr[i]);
            chk("t3_data", wlog[i].d, sent[i]);
        end
        chk("t3_err", err, 0);

        // start while busy (ignored), then abort
        d0 = done_cnt;
        fill_rand();
        run_frame(3, 2, 2, 3, got);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_busy", busy, 0);
        chk("t4_core_valid", bus.core_valid, 0);
        chk("t4_frame_cnt", frame_cnt, 3);
        chk("t4_nwr", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t4_addr", wlog[i].a, 2 + i);
        fill_rand();
        run_frame(4, 9, -1, -1, got);
        chk("t4_next_done", got, 1);
        chk("t4_next_frame_cnt", frame_cnt, 4);

        // start and abort together in IDLE
        map_sel = 3'd5; base_addr = 4'd0; start = 1'b1; abort = 1'b1;
        step();
        chk("idle_abort_wins", busy, 0);

        // reset during LOAD
        fill_rand();
        map_sel = 3'd6; base_addr = 4'd3; start = 1'b1; acc_cnt = 0;
        step();
        for (int c = 0; c < 50 && acc_cnt < 2; c++) step();
        chk("t5_reached_load", acc_cnt >= 2, 1);
        aresetn = 1'b0;
        #1;
        chk("t5_async_clear", {bus.pix_ready, bus.core_map, bus.core_image, bus.core_w_addr,
                               bus.core_valid, busy, done, frame_cnt, err}, 64'd0);
        src_q.delete();
        bus.pix_valid = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        fill_rand();
        run_frame(2, 7, -1, -1, got);
        chk("t5_done", got, 1);
        chk("t5_frame_cnt", frame_cnt, 1);

`ifdef C2P_SEQ_TIMEOUT_EN
        // stall timeout after first pixel
        d0 = done_cnt;
        src_q.push_back(32'h1234);
        map_sel = 3'd2; base_addr = 4'd0; start = 1'b1; acc_cnt = 0;
        step();
        for (int c = 0; c < 50 && acc_cnt < 1; c++) step();
        chk("t6_first_pixel", acc_cnt, 1);
        repeat (TIMEOUT_CYC - 1) step();
        chk("t6_still_busy", busy, 1);
        step();
        chk("t6_idle", busy, 0);
        chk("t6_err", err, 1);
        chk("t6_no_done", done_cnt - d0, 0);
        fill_rand();
        run_frame(5, 1, -1, -1, got);
        chk("t6_next_done", got, 1);
        chk("t6_err_cleared", err, 0);
`endif

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int st_at, ab_at;
            vprob = $urandom_range(100, 60);
            rprob = $urandom_range(100, 40);
            st_at = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : -1;
            ab_at = ($urandom_range(4) == 0) ? int'($urandom_range(NUM_PIX - 1)) : -1;
            fill_rand();
            run_frame(MAP_W'($urandom), ADDR_W'($urandom), st_at, ab_at, got);
            if (ab_at < 0) chk("rand_done", got, 1);
            repeat ($urandom_range(3)) step();
        end

        vprob = 100; rprob = 100;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end
endmodule
